parity_mux_pipe: RTL and testbench

PARITY_MUX_PIPE -- requirements
Module: parity_mux_pipe

---
 rtl/parity_mux_pkg.sv | 24 ++
 rtl/xor_mux_cell.sv | 14 +
 rtl/parity_mux_pipe.sv | 125 ++++++++++++
 tb/tb_parity_mux_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_mux_pkg.sv
// Shared definitions for the mux-built parity pipeline: tree depth helper,
// counter width and the parity mode encoding.
package parity_mux_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {
    MODE_EVEN = 1'b0,
    MODE_ODD  = 1'b1
  } mode_e;

  // Smallest depth whose binary tree covers width leaves (ceil log2, min 1 for width 2).
  function automatic int levels_f(input int width);
    int lv;
    lv = 0;
    for (int i = 0; i < 7; i++) begin
      if ((32'sd1 << lv) < width) begin
        lv = lv + 1;
      end
    end
    return lv;
  endfunction

endpackage

// File: rtl/xor_mux_cell.sv
// Two-input XOR built only from 2:1 multiplexers and the constants 0/1.
module xor_mux_cell (
  input  logic a,
  input  logic b,
  output logic o
);

  logic a_inv;

  // First mux acts as an inverter: picks constant 0 when a=1, constant 1 when a=0.
  assign a_inv = a ? 1'b0 : 1'b1;
  assign o     = b ? a_inv : a;

endmodule

// File: rtl/parity_mux_pipe.sv
// Pipelined parity reducer: one mux-built XOR tree level per stage, valid/ready
// on both sides. Optional txn_cnt output when PARITY_MUX_PIPE_CNT_EN is defined.
module parity_mux_pipe
  import parity_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_odd,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data,
  output logic             down_parity
`ifdef PARITY_MUX_PIPE_CNT_EN
  ,
  output logic [CNT_W-1:0] txn_cnt
`endif
);

  localparam int LEVELS = levels_f(WIDTH);
  localparam int LEAVES = 32'sd1 << LEVELS;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_stg
    localparam int NK = LEAVES >> k;

    logic              valid_r;
    logic [WIDTH-1:0]  data_r;
    logic [NK-1:0]     part_r;
    logic              load_s;
    logic              in_valid_s;
    mode_e             in_mode_s;
    logic [WIDTH-1:0]  in_data_s;
    logic [2*NK-1:0]   in_part_s;
    logic [NK-1:0]     tree_s;
    logic [NK-1:0]     next_part_s;

    if (k == 1) begin : g_first
      assign in_valid_s = up_valid;
      assign in_mode_s  = mode_e'(up_odd);
      assign in_data_s  = up_data;
      // Missing leaves are tied to 0 so they do not disturb the XOR.
      if (LEAVES > WIDTH) begin : g_pad
        assign in_part_s = {{(LEAVES - WIDTH){1'b0}}, up_data};
      end else begin : g_nopad
        assign in_part_s = up_data;
      end
    end else begin : g_chain
      assign in_valid_s = g_stg[k-1].valid_r;
      assign in_mode_s  = g_stg[k-1].g_mode.mode_r;
      assign in_data_s  = g_stg[k-1].data_r;
      assign in_part_s  = g_stg[k-1].part_r;
    end

    if (k == LEVELS) begin : g_last_load
      assign load_s = !valid_r || down_ready;
    end else begin : g_mid_load
      assign load_s = !valid_r || g_stg[k+1].load_s;
    end

    for (genvar j = 0; j < NK; j++) begin : g_cell
      xor_mux_cell u_cell (
        .a (in_part_s[2*j]),
        .b (in_part_s[2*j+1]),
        .o (tree_s[j])
      );
    end

    if (k == LEVELS) begin : g_mode_apply
      // Even mode inverts the XOR result through a mux, using the mode captured with the word.
      assign next_part_s[0] = (in_mode_s == MODE_ODD) ? tree_s[0] : (tree_s[0] ? 1'b0 : 1'b1);
    end else begin : g_mode_pass
      assign next_part_s = tree_s;
    end

    // Stage register: advances whenever this stage is empty or its successor drains.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r <= 1'b0;
        data_r  <= {WIDTH{1'b0}};
        part_r  <= {NK{1'b0}};
      end else if (load_s) begin
        valid_r <= in_valid_s;
        data_r  <= in_data_s;
        part_r  <= next_part_s;
      end
    end

    if (k < LEVELS) begin : g_mode
      mode_e mode_r;
      // Mode travels with the word until the final stage consumes it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mode_r <= MODE_EVEN;
        end else if (load_s) begin
          mode_r <= in_mode_s;
        end
      end
    end
  end

  assign up_ready    = g_stg[1].load_s;
  assign down_valid  = g_stg[LEVELS].valid_r;
  assign down_data   = g_stg[LEVELS].data_r;
  assign down_parity = g_stg[LEVELS].part_r[0];

`ifdef PARITY_MUX_PIPE_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Saturating count of downstream handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (down_valid && down_ready && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign txn_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_parity_mux_pipe.sv
// Randomized bench for parity_mux_pipe (WIDTH=8 and WIDTH=5) against a
// queue-based parity model; covers latency, stall, reset flush and draining.
module tb_parity_mux_pipe;

  localparam int LEV8 = 3;
  localparam int LEV5 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       uv8, ur8, uo8, dv8, dr8, dp8;
  logic [7:0] ud8, dd8;
  logic       uv5, ur5, uo5, dv5, dr5, dp5;
  logic [4:0] ud5, dd5;
`ifdef PARITY_MUX_PIPE_CNT_EN
  logic [15:0] txn8, txn5;
`endif

  parity_mux_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .up_valid(uv8), .up_ready(ur8), .up_data(ud8), .up_odd(uo8),
    .down_valid(dv8), .down_ready(dr8), .down_data(dd8), .down_parity(dp8)
`ifdef PARITY_MUX_PIPE_CNT_EN
    , .txn_cnt(txn8)
`endif
  );

  parity_mux_pipe #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .up_valid(uv5), .up_ready(ur5), .up_data(ud5), .up_odd(uo5),
    .down_valid(dv5), .down_ready(dr5), .down_data(dd5), .down_parity(dp5)
`ifdef PARITY_MUX_PIPE_CNT_EN
    , .txn_cnt(txn5)
`endif
  );

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cyc = 0;
  int   hs8 = 0;
  int   hs5 = 0;
  logic chk_lat = 1'b0;
  logic stalled8 = 1'b0, stalled5 = 1'b0;
  logic [7:0] hd8;
  logic [4:0] hd5;
  logic hp8, hp5;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Parity by counting ones: odd mode reports 1 for an odd count, even mode for an even count.
  function automatic logic ref_par(input logic [7:0] d, input int w, input logic odd);
    int ones;
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'(d[i]);
    return (((ones % 2) == 1) == (odd == 1'b1));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for the WIDTH=8 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
      hs8 = 0;
      stalled8 = 1'b0;
    end else begin
      exp_t e;
      if (dv8 && stalled8) begin
        check("hold_data8", 64'(dd8), 64'(hd8));
        check("hold_par8", 64'(dp8), 64'(hp8));
      end
      if (dv8 && dr8) begin
        hs8++;
        check("pending8", 64'(q8.size() > 0), 64'd1);
        if (q8.size() > 0) begin
          e = q8.pop_front();
          check("data8", 64'(dd8), 64'(e.data));
          check("par8", 64'(dp8), 64'(e.par));
          if (chk_lat) check("lat8", 64'(cyc - e.cyc), 64'(LEV8));
        end
      end
      stalled8 = dv8 && !dr8;
      hd8 = dd8;
      hp8 = dp8;
      if (uv8 && ur8) q8.push_back(exp_t'{ud8, ref_par(ud8, 8, uo8), cyc});
    end
  end

  // Scoreboard for the WIDTH=5 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      q5.delete();
      hs5 = 0;
      stalled5 = 1'b0;
    end else begin
      exp_t e;
      if (dv5 && stalled5) begin
        check("hold_data5", 64'(dd5), 64'(hd5));
        check("hold_par5", 64'(dp5), 64'(hp5));
      end
      if (dv5 && dr5) begin
        hs5++;
        check("pending5", 64'(q5.size() > 0), 64'd1);
        if (q5.size() > 0) begin
          e = q5.pop_front();
          check("data5", 64'({3'b000, dd5}), 64'(e.data));
          check("par5", 64'(dp5), 64'(e.par));
          if (chk_lat) check("lat5", 64'(cyc - e.cyc), 64'(LEV5));
        end
      end
      stalled5 = dv5 && !dr5;
      hd5 = dd5;
      hp5 = dp5;
      if (uv5 && ur5) q5.push_back(exp_t'{{3'b000, ud5}, ref_par({3'b000, ud5}, 5, uo5), cyc});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] tab [8];
  int acc;

  initial begin
    rst_n = 1'b0;
    uv8 = 1'b0; ud8 = 8'h00; uo8 = 1'b0; dr8 = 1'b1;
    uv5 = 1'b0; ud5 = 5'h00; uo5 = 1'b0; dr5 = 1'b1;
    step();
    check("rst_dv8", 64'(dv8), 64'd0);
    check("rst_dd8", 64'(dd8), 64'd0);
    check("rst_dp8", 64'(dp8), 64'd0);
    check("rst_ur8", 64'(ur8), 64'd1);
    check("rst_dv5", 64'(dv5), 64'd0);
    check("rst_ur5", 64'(ur5), 64'd1);
`ifdef PARITY_MUX_PIPE_CNT_EN
    check("rst_txn8", 64'(txn8), 64'd0);
`endif
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("idle_ur8", 64'(ur8), 64'd1);

    // Back-to-back directed words; {odd, data}.
    tab = '{9'h1A5, 9'h1A4, 9'h0A4, 9'h000, 9'h101, 9'h103, 9'h107, 9'h1FF};
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      uv8 = 1'b1;
      {uo8, ud8} = tab[i];
      uv5 = (i < 3);
      ud5 = (i == 0) ? 5'b10110 : 5'($urandom);
      uo5 = (i == 0) ? 1'b1 : 1'($urandom);
      step();
    end
    uv8 = 1'b0;
    uv5 = 1'b0;
    repeat (6) step();
    chk_lat = 1'b0;
    check("hs5_directed", 64'(hs5), 64'd3);
`ifdef PARITY_MUX_PIPE_CNT_EN
    check("txn5_directed", 64'(txn5), 64'd3);
    check("txn8_directed", 64'(txn8), 64'd8);
`endif

    // Downstream stall: capacity is exactly LEVELS words.
    dr8 = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      uv8 = 1'b1;
      ud8 = 8'($urandom);
      uo8 = 1'($urandom);
      if (ur8) acc++;
      step();
    end
    uv8 = 1'b0;
    check("cap8", 64'(acc), 64'(LEV8));
    check("stall_ur8", 64'(ur8), 64'd0);
    check("stall_dv8", 64'(dv8), 64'd1);
    repeat (3) step();
    dr8 = 1'b1;
    repeat (5) step();
    check("drained_q8", 64'(q8.size()), 64'd0);

    // Reset with words in flight.
    dr8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      uv8 = 1'b1;
      ud8 = 8'($urandom);
      uo8 = 1'($urandom);
      step();
    end
    uv8 = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_dv8", 64'(dv8), 64'd0);
    check("midrst_dd8", 64'(dd8), 64'd0);
    check("midrst_dp8", 64'(dp8), 64'd0);
    check("midrst_ur8", 64'(ur8), 64'd1);
    repeat (2) step();
    rst_n = 1'b1;
    dr8 = 1'b1;
    repeat (5) step();
    uv8 = 1'b1; ud8 = 8'h3C; uo8 = 1'b0;
    step();
    uv8 = 1'b0;
    repeat (5) step();
    check("post_rst_hs8", 64'(hs8), 64'd1);

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      uv8 = ($urandom_range(0, 3) != 0);
      ud8 = 8'($urandom);
      uo8 = 1'($urandom);
      dr8 = ($urandom_range(0, 9) < 7);
      uv5 = ($urandom_range(0, 3) != 0);
      ud5 = 5'($urandom);
      uo5 = 1'($urandom);
      dr5 = ($urandom_range(0, 9) < 6);
      step();
    end
    uv8 = 1'b0; uv5 = 1'b0; dr8 = 1'b1; dr5 = 1'b1;
    for (int i = 0; i < 40 && (q8.size() > 0 || q5.size() > 0); i++) step();
    check("final_q8", 64'(q8.size()), 64'd0);
    check("final_q5", 64'(q5.size()), 64'd0);
    check("final_dv8", 64'(dv8), 64'd0);
`ifdef PARITY_MUX_PIPE_CNT_EN
    check("final_txn8", 64'(txn8), 64'(hs8));
    check("final_txn5", 64'(txn5), 64'(hs5));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
